// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency ROM among NUM_REQ requesters.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
module rom_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rom_read_enable,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_out
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e state_q;
  idx_t   gnt_q;
  idx_t   gnt_idx;
  logic   gnt_found;

`ifndef ROM_ARB_FIXED_PRIO_EN
  idx_t rr_ptr_q;
  idx_t rr_ptr_next;

  assign rr_ptr_next = (gnt_q == idx_t'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
`endif

  // Search starts at the rotating pointer and wraps modulo NUM_REQ.
  always_comb begin
    int unsigned sum;
    idx_t        cand;
    sum       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      sum = k;
`else
      sum = 32'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
`endif
      cand = idx_t'(sum);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      gnt_q           <= '0;
      rom_read_enable <= 1'b0;
      rom_addr        <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr_q        <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state_q)
        StIdle: begin
          // Address goes straight to the ROM pins so read_enable is high during ISSUE.
          if (gnt_found) begin
            gnt_q           <= gnt_idx;
            rom_addr        <= req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
            rom_read_enable <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          rom_read_enable <= 1'b0;
          state_q         <= StCapture;
        end
        StCapture: begin
          rsp_data         <= rom_out;
          rsp_valid[gnt_q] <= 1'b1;
`ifndef ROM_ARB_FIXED_PRIO_EN
          rr_ptr_q         <= rr_ptr_next;
`endif
          state_q          <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomized and directed bench for rom_read_arbiter against a transaction-timing model.
// Honours ROM_ARB_FIXED_PRIO_EN the same way as the design.
module tb_rom_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rom_read_enable;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_out;

  always #5 clk = ~clk;

  rom_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rom_read_enable (rom_read_enable),
    .rom_addr        (rom_addr),
    .rom_out         (rom_out)
  );

  // 16x4 ROM, mem[a] = F - a, registered output.
  always @(posedge clk) begin
    if (rom_read_enable) rom_out <= 4'hF - rom_addr;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: a read granted in cycle g has read_enable in g+1, response in g+3, and the
  // arbiter is free again in g+3.
  int         cyc;
  int         m_gcyc = -100;
  int         m_gidx = 0;
  int         m_ptr  = 0;
  logic [3:0] m_addr = '0;
  logic [3:0] m_data = '0;

  logic [N-1:0]  s_ready, s_rv;
  logic [DW-1:0] s_data;
  logic          s_ren;
  logic [AW-1:0] s_raddr;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    int         p;
    logic [3:0] e_ready, e_rv;
    @(negedge clk);
    p       = pick(req_valid, m_ptr);
    e_ready = (!rst && cyc >= m_gcyc + 3 && p >= 0) ? 4'(1 << p) : 4'b0;
    e_rv    = (cyc == m_gcyc + 3) ? 4'(1 << m_gidx) : 4'b0;
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_data));
    check_eq("rom_read_enable", 32'(rom_read_enable), 32'(cyc == m_gcyc + 1));
    check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    s_ready = req_ready; s_rv = rsp_valid; s_data = rsp_data;
    s_ren = rom_read_enable; s_raddr = rom_addr;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_data = '0; m_addr = '0; m_gcyc = -100; m_gidx = 0;
    end else begin
      if (cyc == m_gcyc + 2) m_data = 4'hF - m_addr;
      if (cyc >= m_gcyc + 3 && p >= 0) begin
        m_gcyc = cyc;
        m_gidx = p;
        m_addr = req_addr[p*AW +: AW];
`ifndef ROM_ARB_FIXED_PRIO_EN
        m_ptr = (p + 1) % N;
`endif
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int g_idx[5];
    int g_cyc[5];
    int n_g;
    logic [3:0] d_seq[4];
    int n_d;
    logic [3:0] exp_d[4];

    rst = 1'b1; req_valid = '0; req_addr = '0; cyc = 0;
    @(posedge clk); #1;

    // 1: reset held, then idle
    tick(); tick();
    check_eq("t1_rsp_data", 32'(s_data), 0);
    check_eq("t1_rsp_valid", 32'(s_rv), 0);
    check_eq("t1_ren", 32'(s_ren), 0);
    check_eq("t1_raddr", 32'(s_raddr), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_ren) cnt++;
    end
    check_eq("t1_idle_no_read", 32'(cnt), 0);

    // 2: single read of addr 3
    req_valid = 4'b0001; req_addr = 16'h0003;
    tick();
    check_eq("t2_ready", 32'(s_ready), 32'h1);
    req_valid = '0;
    tick();
    check_eq("t2_ren", 32'(s_ren), 1);
    check_eq("t2_raddr", 32'(s_raddr), 3);
    tick(); tick();
    check_eq("t2_rsp_valid", 32'(s_rv), 32'h1);
    check_eq("t2_rsp_data", 32'(s_data), 32'hC);

    // 3: all four valid continuously
    do_reset();
    req_valid = 4'b1111; req_addr = 16'hF210;
    n_g = 0; n_d = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_ready != 0 && n_g < 5) begin
        for (int k = 0; k < N; k++) if (s_ready[k]) g_idx[n_g] = k;
        g_cyc[n_g] = i;
        n_g++;
      end
      if (s_rv != 0 && n_d < 4) begin
        d_seq[n_d] = s_data;
        n_d++;
      end
    end
    req_valid = '0;
    check_eq("t3_num_grants", 32'(n_g), 5);
    check_eq("t3_num_rsps", 32'(n_d), 4);
    exp_d[0] = 4'hF; exp_d[1] = 4'hE; exp_d[2] = 4'hD; exp_d[3] = 4'h0;
    for (int k = 0; k < n_g; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      check_eq("t3_grant_idx", 32'(g_idx[k]), 0);
`else
      check_eq("t3_grant_idx", 32'(g_idx[k]), 32'(k % N));
`endif
      check_eq("t3_grant_spacing", 32'(g_cyc[k]), 32'(3 * k));
    end
`ifndef ROM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < n_d; k++) check_eq("t3_rsp_data", 32'(d_seq[k]), 32'(exp_d[k]));
`endif
    tick(); tick(); tick();

    // 4: 1 and 3 valid after a grant to 1
    do_reset();
    req_valid = 4'b0010; req_addr = 16'h0070;
    tick();
    check_eq("t4_first_grant", 32'(s_ready), 32'h2);
    req_valid = 4'b1010;
    tick(); tick(); tick();
`ifdef ROM_ARB_FIXED_PRIO_EN
    check_eq("t4_next_grant", 32'(s_ready), 32'h2);
`else
    check_eq("t4_next_grant", 32'(s_ready), 32'h8);
`endif
    req_valid = '0;
    tick(); tick(); tick();

    // 5: reset during ISSUE
    do_reset();
    req_valid = 4'b0001; req_addr = 16'h0005;
    tick();
    check_eq("t5_ready", 32'(s_ready), 32'h1);
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    tick();
    check_eq("t5_ren_after_rst", 32'(s_ren), 0);
    if (s_rv != 0) cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_rv != 0) cnt++;
    end
    check_eq("t5_no_rsp", 32'(cnt), 0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    check_eq("t5_rsp_valid", 32'(s_rv), 32'h1);
    check_eq("t5_rsp_data", 32'(s_data), 32'hA);

    // 6: back-to-back acceptance in the response cycle
    req_valid = 4'b0001; req_addr = 16'h0002;
    tick();
    req_valid = '0;
    tick(); tick();
    req_valid = 4'b0100; req_addr = 16'h0900;
    tick();
    check_eq("t6_rsp_valid", 32'(s_rv), 32'h1);
    check_eq("t6_ready", 32'(s_ready), 32'h4);
    req_valid = '0;
    tick(); tick(); tick();

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom);
      req_addr  = (N*AW)'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
